// File: rtl/seq_matrix_mac_pkg.sv
// Shared types and helpers for the sequential matrix MAC and related arithmetic blocks.
// Element (i,j) of an N x N matrix sits at bit offset (i*N+j)*WIDTH of a flat vector.
package seq_matrix_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widest intermediate sum the saturation helper accepts (2*WIDTH+1 must stay below this).
    localparam int unsigned MAX_SUM_W = 33;

    function automatic int unsigned elem_off(input int unsigned i, input int unsigned j,
                                             input int unsigned n, input int unsigned w);
        return (i * n + j) * w;
    endfunction

    // True when sum no longer fits in width bits, i.e. the value must clamp to 2^width-1.
    function automatic logic sat_over(input logic [MAX_SUM_W-1:0] sum,
                                      input int unsigned width);
        logic [MAX_SUM_W-1:0] lim;
        lim = MAX_SUM_W'(1) << width;
        return (sum >= lim);
    endfunction

endpackage

// File: rtl/seq_matrix_mac_mac_cell.sv
// One accumulator of the matrix MAC: clear, one multiply-accumulate step, or hold.
// Wrap or saturating result, chosen at elaboration by SATURATE.
import seq_matrix_mac_pkg::*;

module mac_cell #(
    parameter int unsigned WIDTH    = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             step,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] acc
);

    localparam int unsigned SUM_W = 2 * WIDTH + 1;

    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0] prod;
    logic [SUM_W-1:0]   sum;
    logic               over;

    always_comb begin
        prod  = {{WIDTH{1'b0}}, a_in} * {{WIDTH{1'b0}}, b_in};
        sum   = {1'b0, prod} + {{(WIDTH + 1){1'b0}}, acc_q};
        over  = sat_over({{(MAX_SUM_W - SUM_W){1'b0}}, sum}, WIDTH);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (step) begin
            // Clamping every step keeps a saturated cell pinned for the rest of the job.
            acc_d = (SATURATE && over) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/seq_matrix_mac.sv
// N x N matrix multiply-accumulate, one k-step per clock across all cells.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
import seq_matrix_mac_pkg::*;

module seq_matrix_mac #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned N        = 2,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 acc_en,
    input  logic [N*N*WIDTH-1:0] a_mat,
    input  logic [N*N*WIDTH-1:0] b_mat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*N*WIDTH-1:0] c_mat,
    output logic                 busy
);

    localparam int unsigned KW    = $clog2(N);
    localparam int unsigned MAT_W = N * N * WIDTH;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [MAT_W-1:0] a_q, a_d;
    logic [MAT_W-1:0] b_q, b_d;
    logic             out_valid_q, out_valid_d;
    logic             acc_clr;
    logic             acc_step;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        out_valid_d = 1'b0;
        acc_clr     = 1'b0;
        acc_step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_mat;
                    b_d     = b_mat;
                    k_d     = '0;
                    acc_clr = !acc_en;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_step = 1'b1;
                if (k_q == KW'(N - 1)) begin
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                // out_valid rises one cycle after entering DONE, once the last step has settled.
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic [WIDTH-1:0] a_sel;
            logic [WIDTH-1:0] b_sel;
            logic [WIDTH-1:0] acc;

            // Cell (i,j) consumes A[i][k] and B[k][j] for the current k.
            assign a_sel = a_q[elem_off(gi, 32'(k_q), N, WIDTH) +: WIDTH];
            assign b_sel = b_q[elem_off(32'(k_q), gj, N, WIDTH) +: WIDTH];

            mac_cell #(
                .WIDTH    (WIDTH),
                .SATURATE (SATURATE)
            ) u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (acc_clr),
                .step  (acc_step),
                .a_in  (a_sel),
                .b_in  (b_sel),
                .acc   (acc)
            );

            assign c_mat[elem_off(gi, gj, N, WIDTH) +: WIDTH] = acc;
        end
    end

endmodule

// File: tb/tb_seq_matrix_mac.sv
// Directed bench for seq_matrix_mac: 2x2 wrap and saturate builds driven in lockstep,
// plus a 3x3, 8-bit wrap build checked against a small reference model.
module tb_seq_matrix_mac;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        acc_en = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a_mat = '0;
    logic [15:0] b_mat = '0;
    logic        in_ready_w, out_valid_w, busy_w;
    logic        in_ready_s, out_valid_s, busy_s;
    logic [15:0] c_w, c_s;

    logic        in_valid3 = 1'b0;
    logic        acc_en3 = 1'b0;
    logic        out_ready3 = 1'b0;
    logic [71:0] a3 = '0;
    logic [71:0] b3 = '0;
    logic        in_ready3, out_valid3, busy3;
    logic [71:0] c3;
    logic [71:0] exp3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_matrix_mac #(.WIDTH(4), .N(2), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .acc_en(acc_en), .a_mat(a_mat), .b_mat(b_mat), .out_valid(out_valid_w),
        .out_ready(out_ready), .c_mat(c_w), .busy(busy_w)
    );

    seq_matrix_mac #(.WIDTH(4), .N(2), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .acc_en(acc_en), .a_mat(a_mat), .b_mat(b_mat), .out_valid(out_valid_s),
        .out_ready(out_ready), .c_mat(c_s), .busy(busy_s)
    );

    seq_matrix_mac #(.WIDTH(8), .N(3), .SATURATE(1'b0)) u_n3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .acc_en(acc_en3), .a_mat(a3), .b_mat(b3), .out_valid(out_valid3),
        .out_ready(out_ready3), .c_mat(c3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // C = A*B mod 256 for 3x3 byte matrices.
    function automatic logic [71:0] model3(input logic [71:0] a, input logic [71:0] b);
        logic [71:0] c;
        logic [7:0]  s;
        logic [15:0] p;
        c = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = '0;
                for (int k = 0; k < 3; k++) begin
                    p = {8'd0, a[(i*3+k)*8 +: 8]} * {8'd0, b[(k*3+j)*8 +: 8]};
                    s = s + p[7:0];
                end
                c[(i*3+j)*8 +: 8] = s;
            end
        end
        return c;
    endfunction

    // One 2x2 job on both builds; hold keeps out_ready low for that many DONE cycles.
    task automatic job2(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic acc, input logic [15:0] exp_w, input logic [15:0] exp_s,
                        input int hold);
        int lat;
        a_mat = a; b_mat = b; acc_en = acc; in_valid = 1'b1; out_ready = 1'b0;
        chk({tag, "_in_ready"}, 72'(in_ready_w & in_ready_s), 72'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, 72'(busy_w & busy_s), 72'(1));
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid_w && lat < 20);
        chk({tag, "_latency"}, 72'(lat), 72'(3));
        chk({tag, "_sat_valid"}, 72'(out_valid_s), 72'(1));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; a_mat = 16'hFFFF; b_mat = 16'hFFFF; acc_en = 1'b0;
            chk({tag, "_hold_valid"}, 72'(out_valid_w & out_valid_s), 72'(1));
            chk({tag, "_hold_ready"}, 72'(in_ready_w | in_ready_s), 72'(0));
            chk({tag, "_hold_c_wrap"}, 72'(c_w), 72'(exp_w));
            chk({tag, "_hold_c_sat"}, 72'(c_s), 72'(exp_s));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk({tag, "_c_wrap"}, 72'(c_w), 72'(exp_w));
        chk({tag, "_c_sat"}, 72'(c_s), 72'(exp_s));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, 72'(out_valid_w | out_valid_s), 72'(0));
        chk({tag, "_back_idle"}, 72'(in_ready_w & in_ready_s & !busy_w & !busy_s), 72'(1));
    endtask

    task automatic job3(input string tag, input logic [71:0] a, input logic [71:0] b,
                        input logic [71:0] exp);
        int lat;
        a3 = a; b3 = b; acc_en3 = 1'b0; in_valid3 = 1'b1; out_ready3 = 1'b0;
        chk({tag, "_in_ready"}, 72'(in_ready3), 72'(1));
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid3 && lat < 20);
        chk({tag, "_latency"}, 72'(lat), 72'(4));
        chk({tag, "_c"}, c3, exp);
        out_ready3 = 1'b1;
        @(posedge clk); #1;
        out_ready3 = 1'b0;
        chk({tag, "_out_valid_drop"}, 72'(out_valid3), 72'(0));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 72'({in_ready_w, in_ready_s, in_ready3}), 72'(3'b111));
        chk("rst_out_valid", 72'({out_valid_w, out_valid_s, out_valid3}), 72'(0));
        chk("rst_busy", 72'({busy_w, busy_s, busy3}), 72'(0));
        chk("rst_c", 72'({c_w, c_s}), 72'(0));
        chk("rst_c3", c3, 72'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Identity times B, then accumulate I*I onto it
        job2("basic", 16'h1001, 16'h8765, 1'b0, 16'h8765, 16'h8765, 0);
        job2("accum", 16'h1001, 16'h1001, 1'b1, 16'h9766, 16'h9766, 0);
        // [[1,2],[3,4]]*[[5,6],[7,8]] = 19,22,43,50; held under backpressure
        job2("wrap_sat", 16'h4321, 16'h8765, 1'b0, 16'h2B63, 16'hFFFF, 5);
        job2("diag15", 16'hF00F, 16'hF00F, 1'b0, 16'h1001, 16'hF00F, 0);

        // Reset in the middle of RUN
        a_mat = 16'h4321; b_mat = 16'h8765; acc_en = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy_before", 72'(busy_w & busy_s), 72'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 72'(out_valid_w | out_valid_s), 72'(0));
        chk("midrst_busy", 72'(busy_w | busy_s), 72'(0));
        chk("midrst_in_ready", 72'(in_ready_w & in_ready_s), 72'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        job2("after_rst", 16'h4321, 16'h1001, 1'b1, 16'h4321, 16'h4321, 0);

        // 3x3, 8-bit: identity times [1..9]
        a3 = '0; b3 = '0;
        for (int i = 0; i < 3; i++) a3[(i*4)*8 +: 8] = 8'd1;
        for (int e = 0; e < 9; e++) b3[e*8 +: 8] = 8'(e + 1);
        job3("n3_ident", a3, b3, 72'h09_08_07_06_05_04_03_02_01);
        // 3 * 17 * 15 = 765 -> 0xFD
        job3("n3_wrap", {9{8'h11}}, {9{8'h0F}}, {9{8'hFD}});
        for (int r = 0; r < 4; r++) begin
            for (int e = 0; e < 9; e++) begin
                a3[e*8 +: 8] = 8'($urandom_range(0, 255));
                b3[e*8 +: 8] = 8'($urandom_range(0, 255));
            end
            exp3 = model3(a3, b3);
            job3("n3_rand", a3, b3, exp3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
